// File: rtl/alu_writeback_ctrl.sv
// alu_writeback_ctrl
// Multi-cycle execute/writeback controller between instruction issue and an
// 8-entry register file. One instruction is accepted per valid/ready
// handshake and walks IDLE -> READ -> EXEC -> WRITE. The register file write
// is presented for exactly one cycle (WRITE), so a write accepted at edge T
// commits at edge T+3. Throughput is one instruction per four cycles.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   instr_valid/ready     instruction handshake
//   op, dst, src1, src2   opcode and register operands of the instruction
//   imm                   immediate for LDI
//   ra1, ra2 / rd1, rd2   register file read addresses / combinational data
//   wa3, wd3, we3         register file write port
//   done                  one-cycle pulse when an instruction retires
//   carry, zero           ALU flags, registered in EXEC (NOP keeps them)
module alu_writeback_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [DW-1:0] imm,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          we3,
  output logic          done,
  output logic          carry,
  output logic          zero
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_reg;
  logic [2:0]    op_reg;
  logic [AW-1:0] dst_reg;
  logic [AW-1:0] src1_reg;
  logic [AW-1:0] src2_reg;
  logic [DW-1:0] imm_reg;
  logic [DW-1:0] opa_reg;
  logic [DW-1:0] opb_reg;
  logic [DW-1:0] res_reg;

  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic [DW:0]   sum_ext;
  logic [DW:0]   diff_ext;

  // Ready is gated by rst so it reads 0 while reset is held, not just after.
  assign instr_ready = (state_reg == IDLE) && !rst;

  // Read addresses come straight from the latched sources in every state.
  assign ra1 = src1_reg;
  assign ra2 = src2_reg;

  // Zero-extended arithmetic: the extra MSB is the carry for ADD and the
  // borrow (opa < opb unsigned) for SUB.
  assign sum_ext  = {1'b0, opa_reg} + {1'b0, opb_reg};
  assign diff_ext = {1'b0, opa_reg} - {1'b0, opb_reg};

  // NOP falls through to the defaults, which reproduce the held result and
  // carry so the WRITE-cycle wd3 still shows the last result.
  always_comb begin
    alu_res   = res_reg;
    alu_carry = carry;
    case (op_reg)
      OP_ADD: begin
        alu_res   = sum_ext[DW-1:0];
        alu_carry = sum_ext[DW];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DW-1:0];
        alu_carry = diff_ext[DW];
      end
      OP_AND: begin
        alu_res   = opa_reg & opb_reg;
        alu_carry = 1'b0;
      end
      OP_OR: begin
        alu_res   = opa_reg | opb_reg;
        alu_carry = 1'b0;
      end
      OP_XOR: begin
        alu_res   = opa_reg ^ opb_reg;
        alu_carry = 1'b0;
      end
      OP_MOV: begin
        alu_res   = opa_reg;
        alu_carry = 1'b0;
      end
      OP_LDI: begin
        alu_res   = imm_reg;
        alu_carry = 1'b0;
      end
      default: begin
        alu_res   = res_reg;
        alu_carry = carry;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      dst_reg   <= '0;
      src1_reg  <= '0;
      src2_reg  <= '0;
      imm_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      wa3       <= '0;
      wd3       <= '0;
      we3       <= 1'b0;
      done      <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      // Write strobe and retire pulse are single-cycle by default.
      we3  <= 1'b0;
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            op_reg    <= op;
            dst_reg   <= dst;
            src1_reg  <= src1;
            src2_reg  <= src2;
            imm_reg   <= imm;
            state_reg <= READ;
          end
        end
        READ: begin
          opa_reg   <= rd1;
          opb_reg   <= rd2;
          state_reg <= EXEC;
        end
        EXEC: begin
          if (op_reg != OP_NOP) begin
            res_reg <= alu_res;
            carry   <= alu_carry;
            zero    <= (alu_res == '0);
          end
          // Write port is loaded here so it is valid for the whole WRITE cycle.
          wa3       <= dst_reg;
          wd3       <= alu_res;
          we3       <= (op_reg != OP_NOP);
          done      <= 1'b1;
          state_reg <= WRITE;
        end
        WRITE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
module tb_alu_writeback_ctrl;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, MOV = 3'd6, LDI = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op;
  logic [2:0] dst, src1, src2;
  logic [7:0] imm;
  logic [2:0] ra1, ra2, wa3;
  logic [7:0] rd1, rd2, wd3;
  logic       we3, done, carry, zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Bench register file: combinational read, write on rising edge.
  logic [7:0] rf [8];
  // Expected register contents and flags (reference model state).
  logic [7:0] mrf [8];
  logic       mc, mz;

  always #5 clk = ~clk;

  alu_writeback_ctrl #(.DW(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa3(wa3), .wd3(wd3), .we3(we3), .done(done), .carry(carry), .zero(zero)
  );

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  typedef struct {
    logic [2:0] op, dst, s1, s2;
    logic [7:0] imm;
    logic       exp_we;
    logic [7:0] exp_wd;
    logic       exp_c, exp_z;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference ALU from the arithmetic rules: returns {carry, result}.
  function automatic logic [8:0] ref_alu(input logic [2:0] o, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] im);
    int r;
    logic c;
    c = 1'b0;
    r = 0;
    case (o)
      ADD:  begin r = int'(a) + int'(b); c = (r > 255); end
      SUB:  begin r = int'(a) - int'(b); c = (a < b); if (r < 0) r += 256; end
      AND_: r = int'(a & b);
      OR_:  r = int'(a | b);
      XOR_: r = int'(a ^ b);
      MOV:  r = int'(a);
      LDI:  r = int'(im);
      default: r = 0;
    endcase
    return {c, r[7:0]};
  endfunction

  // Issue one instruction and observe its whole lifetime at negedges.
  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [7:0] im,
                       output int we_cnt, output int done_cnt, output int done_k,
                       output logic [2:0] wa_s, output logic [7:0] wd_s,
                       output logic c_s, output logic z_s, output int busy_rdy,
                       output logic [2:0] ra1_s, output logic [2:0] ra2_s);
    we_cnt = 0; done_cnt = 0; done_k = -1; busy_rdy = 0;
    wa_s = '0; wd_s = '0; c_s = 1'b0; z_s = 1'b0; ra1_s = '0; ra2_s = '0;
    for (int w = 0; w < 20 && !instr_ready; w++) @(negedge clk);
    chk("ready_before_issue", instr_ready, 1'b1);
    op = o; dst = d; src1 = s1; src2 = s2; imm = im; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin ra1_s = ra1; ra2_s = ra2; end
      if (k <= 3 && instr_ready) busy_rdy++;
      if (we3) begin we_cnt++; wa_s = wa3; wd_s = wd3; end
      if (done) begin done_cnt++; done_k = k; c_s = carry; z_s = zero; end
    end
  endtask

  task automatic run_chk(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] im, input logic exp_we,
                         input logic [7:0] exp_wd, input logic exp_c, input logic exp_z);
    int we_cnt, done_cnt, done_k, busy_rdy;
    logic [2:0] wa_s, ra1_s, ra2_s;
    logic [7:0] wd_s;
    logic c_s, z_s;
    issue(o, d, s1, s2, im, we_cnt, done_cnt, done_k, wa_s, wd_s, c_s, z_s, busy_rdy, ra1_s, ra2_s);
    $display("instr op=%0d dst=%0d src=%0d,%0d imm=%02h -> we=%0d wa3=%0d wd3=%02h c=%0b z=%0b done_cycle=%0d",
             o, d, s1, s2, im, we_cnt, wa_s, wd_s, c_s, z_s, done_k);
    chk("we3_pulses", we_cnt, exp_we ? 1 : 0);
    chk("done_pulses", done_cnt, 1);
    chk("done_latency", done_k, 3);
    chk("ready_while_busy", busy_rdy, 0);
    chk("ra1", ra1_s, s1);
    chk("ra2", ra2_s, s2);
    if (exp_we) begin
      chk("wa3", wa_s, d);
      chk("wd3", wd_s, exp_wd);
    end
    chk("carry", c_s, exp_c);
    chk("zero", z_s, exp_z);
    if (exp_we) mrf[d] = exp_wd;
    mc = exp_c;
    mz = exp_z;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; mrf[i] = 8'h00; end
    mc = 1'b0; mz = 1'b0;

    vt[0]  = '{LDI,  3'd3, 3'd0, 3'd0, 8'h63, 1'b1, 8'h63, 1'b0, 1'b0};
    vt[1]  = '{LDI,  3'd2, 3'd0, 3'd0, 8'h77, 1'b1, 8'h77, 1'b0, 1'b0};
    vt[2]  = '{ADD,  3'd1, 3'd2, 3'd3, 8'h00, 1'b1, 8'hDA, 1'b0, 1'b0};
    vt[3]  = '{LDI,  3'd4, 3'd0, 3'd0, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[4]  = '{LDI,  3'd5, 3'd0, 3'd0, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[5]  = '{ADD,  3'd6, 3'd4, 3'd5, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
    vt[6]  = '{NOP,  3'd7, 3'd1, 3'd2, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[7]  = '{LDI,  3'd4, 3'd0, 3'd0, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0};
    vt[8]  = '{LDI,  3'd5, 3'd0, 3'd0, 8'h20, 1'b1, 8'h20, 1'b0, 1'b0};
    vt[9]  = '{SUB,  3'd7, 3'd4, 3'd5, 8'h00, 1'b1, 8'hF0, 1'b1, 1'b0};
    vt[10] = '{AND_, 3'd7, 3'd4, 3'd4, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0};
    vt[11] = '{SUB,  3'd0, 3'd4, 3'd5, 8'h00, 1'b1, 8'hF0, 1'b1, 1'b0};

    // Reset held with a valid instruction pending.
    rst = 1'b1; instr_valid = 1'b1; op = LDI; dst = 3'd5; src1 = 3'd6; src2 = 3'd7; imm = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_we3", we3, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_ra1", ra1, 3'd0);
    chk("rst_ra2", ra2, 3'd0);
    chk("rst_wa3", wa3, 3'd0);
    chk("rst_wd3", wd3, 8'd0);
    rst = 1'b0; instr_valid = 1'b0;
    #1 chk("ready_after_release", instr_ready, 1'b1);
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 12; i++)
      run_chk(vt[i].op, vt[i].dst, vt[i].s1, vt[i].s2, vt[i].imm,
              vt[i].exp_we, vt[i].exp_wd, vt[i].exp_c, vt[i].exp_z);

    // Mid-op reset during EXEC of ADD r1,r2,r3 (carry is 1 from the last SUB).
    begin
      int we_seen;
      we_seen = 0;
      op = ADD; dst = 3'd1; src1 = 3'd2; src2 = 3'd3; imm = 8'h00; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);             // READ
      @(negedge clk);             // EXEC
      rst = 1'b1;
      #1;
      chk("midrst_carry", carry, 1'b0);
      chk("midrst_zero", zero, 1'b0);
      chk("midrst_ready", instr_ready, 1'b0);
      if (we3) we_seen++;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("midrst_ready_after", instr_ready, 1'b1);
      for (int k = 0; k < 5; k++) begin
        if (we3) we_seen++;
        @(negedge clk);
      end
      chk("midrst_no_write", we_seen, 0);
      chk("midrst_r1_kept", rf[1], mrf[1]);
      $display("midop reset: we3 pulses=%0d r1=%02h", we_seen, rf[1]);
      mc = 1'b0; mz = 1'b0;
      run_chk(LDI, 3'd1, 3'd0, 3'd0, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0);
    end

    // Backpressure: instr_valid held high for 12 cycles.
    begin
      int acc, dcnt, wcnt;
      int acc_k [3];
      acc = 0; dcnt = 0; wcnt = 0;
      op = LDI; dst = 3'd0; src1 = 3'd0; src2 = 3'd0; imm = 8'h5A; instr_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
        if (instr_ready) begin
          if (acc < 3) acc_k[acc] = k;
          acc++;
        end
        if (done) dcnt++;
        if (we3) wcnt++;
        @(negedge clk);
      end
      instr_valid = 1'b0;
      $display("backpressure: accepts=%0d done=%0d we3=%0d", acc, dcnt, wcnt);
      chk("bp_accepts", acc, 3);
      chk("bp_done", dcnt, 3);
      chk("bp_we3", wcnt, 3);
      if (acc >= 3) begin
        chk("bp_spacing1", acc_k[1] - acc_k[0], 4);
        chk("bp_spacing2", acc_k[2] - acc_k[1], 4);
      end
      mrf[0] = 8'h5A; mc = 1'b0; mz = 1'b0;
      @(negedge clk);
    end

    // Randomized instructions against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] o, d, s1, s2;
      logic [7:0] im;
      logic [8:0] r;
      o = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      s1 = 3'($urandom_range(0, 7));
      s2 = 3'($urandom_range(0, 7));
      im = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r = ref_alu(o, mrf[s1], mrf[s2], im);
      if (o == NOP) run_chk(o, d, s1, s2, im, 1'b0, 8'h00, mc, mz);
      else run_chk(o, d, s1, s2, im, 1'b1, r[7:0], r[8], (r[7:0] == 8'h00));
    end

    // Final register file contents.
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), rf[i], mrf[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_writeback_ctrl.md
Name: alu_writeback_ctrl

Overview:
Multi-cycle execute/writeback controller that sits between instruction issue and the 8-entry register file.
- Accepts one instruction per valid/ready handshake.
- Drives the register file read addresses and captures both read operands.
- Computes an 8-bit ALU result, then drives the register file write port for exactly one cycle.
- Consumes rd1/rd2 from the register file and produces wa3/wd3/we3 for it.

Parameters:
DW, 8, data width of operands, result and immediate
AW, 3, register address width (2**AW registers)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present on op/dst/src1/src2/imm
instr_ready  output  1  block can accept an instruction this cycle
op  input  3  opcode: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MOV, 111 LDI
dst  input  AW  destination register
src1  input  AW  first source register
src2  input  AW  second source register
imm  input  DW  immediate value for LDI
ra1  output  AW  register file read address 1
ra2  output  AW  register file read address 2
rd1  input  DW  register file read data 1 (combinational w.r.t. ra1)
rd2  input  DW  register file read data 2 (combinational w.r.t. ra2)
wa3  output  AW  register file write address
wd3  output  DW  register file write data
we3  output  1  register file write enable
done  output  1  one-cycle pulse when an instruction retires
carry  output  1  carry/borrow flag
zero  output  1  result-zero flag

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous, active-high; while asserted all state clears immediately.
  - Reset values: FSM=IDLE, ra1=0, ra2=0, wa3=0, wd3=0, we3=0, done=0, carry=0, zero=0, latched fields=0.
  - instr_ready = (state==IDLE) & ~rst, so it is 0 during reset and 1 in the first cycle after release.
- FSM states IDLE -> READ -> EXEC -> WRITE -> IDLE:
  - IDLE: instr_ready=1. If instr_valid is high at a rising edge, latch op/dst/src1/src2/imm and go to READ. Otherwise stay in IDLE.
  - READ: ra1/ra2 equal the latched src1/src2, driven combinationally from the latches. At the edge, capture rd1->opA and rd2->opB, then go to EXEC.
  - EXEC: at the edge, register the result and flags, then go to WRITE.
  - WRITE: wa3=dst and wd3=result. we3=1 for this cycle only, except for NOP where we3=0. done=1 for this cycle for every op, including NOP. Next state is IDLE.
- Latency and throughput:
  - Accept edge T; the register file write commits at edge T+3.
  - Throughput is one instruction per 4 cycles.
  - No pipelining and no hazards: a dependent next instruction always reads the committed value.
- instr_valid while busy is ignored (not accepted). An instruction is accepted exactly once per handshake.
- Arithmetic is modulo 2**DW:
  - ADD: {carry,res} = opA+opB.
  - SUB: res = opA-opB; carry = 1 when opA<opB unsigned (borrow).
  - AND/OR/XOR: bitwise; carry=0.
  - MOV: res = opA; carry=0.
  - LDI: res = imm; carry=0.
- zero = (res==0), updated in EXEC for all ops except NOP. NOP leaves carry, zero and the result register unchanged.
- Outputs: wa3/wd3 hold their last values outside WRITE; only we3 qualifies them. ra1/ra2 hold the latched sources in all states.
- Reset mid-operation (any state): the instruction is dropped, no write occurs, and the next accept is possible in the first cycle after rst deasserts.
- dst == src1/src2 is legal: operands were captured in READ, so the write in WRITE is correct.

Test Plan:
- Reset:
  - Assert rst with instr_valid=1 -> all outputs 0, instr_ready=0.
  - Release rst -> instr_ready=1 on the next cycle.
- LDI and ADD (bench models the 8x8 register file: combinational read, write on rising edge):
  - LDI r3,0x63; then LDI r2,0x77 -> we3 pulses once per instruction at T+3 with wa3=3, wd3=0x63, then wa3=2, wd3=0x77.
  - ADD r1,r2,r3 -> wd3=0xDA, wa3=1, carry=0, zero=0, done pulses once.
- ADD overflow: r4=0xFF, r5=0x01, ADD r6,r4,r5 -> wd3=0x00, carry=1, zero=1.
- SUB borrow: r4=0x10, r5=0x20, SUB r7,r4,r5 -> wd3=0xF0, carry=1, zero=0. Then AND r7,r4,r4 -> 0x10, carry=0.
- NOP and backpressure:
  - NOP -> done pulses, we3 stays 0, flags keep their prior values.
  - Hold instr_valid high continuously over 3 instructions -> exactly 3 accepts, 4 cycles apart, 3 done pulses.
- Mid-op reset: assert rst during EXEC of ADD r1 -> no we3 pulse, r1 unchanged, carry/zero=0; a new LDI completes normally after release.
